multi_rate_divider: RTL
=======================

Name: multi_rate_divider

Overview:
- Parametrised, multi-channel successor of the single-rate tick generator.
- Each of CHANNELS independent channels divides CLOCK_50 by a per-channel runtime rate and emits one-cycle update ticks.
- Adds per-channel enable, synchronous phase restart and a one-shot (delay timer) mode.
- Feeds game-logic update clocks, such as dot fall speed and obstacle scroll, plus one-shot delays, such as the flap impulse and game-over pause.

Parameters:
CHANNELS, 4, number of independent divider channels (>=1)
WIDTH, 29, counter and rate width in bits (>=1)

Ports:
CLOCK_50  input  1  system clock
resetn  input  1  asynchronous active-low reset
enable  input  CHANNELS  per-channel count enable; bit i controls channel i
oneshot  input  CHANNELS  per-channel mode: 0 = periodic, 1 = one-shot
restart  input  CHANNELS  per-channel synchronous reload/arm strobe
rate  input  CHANNELS*WIDTH  packed reload values; channel i at [i*WIDTH +: WIDTH]
tick  output  CHANNELS  registered one-cycle pulse per channel
armed  output  CHANNELS  one-shot channel counting toward its tick (always 0 in periodic mode)

Behaviour:
- Clock and reset:
  - Single clock domain CLOCK_50; all state updates on posedge.
  - resetn low (async, active-low) forces for all i: cnt[i]=0, tick[i]=0, armed[i]=0.
  - Deassertion takes effect at the next posedge.
- Per channel i: WIDTH-bit down-counter cnt. Channels are fully independent; no shared state.
- Priority at each posedge: reset > restart > mode behaviour.
- Restart (restart[i]=1), any mode, regardless of enable:
  - cnt<=rate[i], tick<=0.
  - armed<=oneshot[i].
- Periodic mode (oneshot[i]=0, restart[i]=0):
  - armed<=0.
  - enable=0: cnt holds, tick<=0.
  - enable=1 and cnt==0: tick<=1, cnt<=rate[i].
  - enable=1 and cnt!=0: tick<=0, cnt<=cnt-1.
  - Period is rate+1 enabled cycles; tick high exactly 1 cycle per period.
  - rate=0 gives tick continuously high while enabled.
  - After reset, cnt=0, so the first tick is registered on the first enabled edge.
- One-shot mode (oneshot[i]=1, restart[i]=0), two states IDLE (armed=0) and ARMED (armed=1):
  - IDLE: cnt holds, tick<=0; no ticks without a restart.
  - ARMED with enable=0: cnt holds (pause), tick<=0.
  - ARMED with enable=1 and cnt!=0: cnt<=cnt-1, tick<=0.
  - ARMED with enable=1 and cnt==0: tick<=1, armed<=0 (to IDLE), cnt holds at 0.
  - Tick is asserted rate+1 enabled edges after the restart edge.
- Rate changes:
  - rate is sampled only on reload (periodic wrap or restart).
  - A change mid-count takes effect at the next reload.
- Mode changes:
  - 1→0 mid-count: armed clears on that edge; periodic counting continues from the current cnt.
  - 0→1 without restart: channel is IDLE; cnt holds.
- Restart while a tick is due (cnt==0, enabled): restart wins; no tick that cycle.
- Counter arithmetic is modulo 2^WIDTH, but underflow cannot occur because reload happens at 0.
- Reset mid-count: all state is cleared immediately; no tick is generated by or during reset.

Test Plan:
- Periodic, CHANNELS=4, WIDTH=29: ch0 rate=3, enable=1 after reset -> tick0 high on edges 1,5,9,13 after release (period 4, width 1); ch1 rate=0 -> tick1 constantly 1.
- Enable gating: ch0 rate=4, drop enable for 7 cycles mid-count -> cnt frozen, no ticks; resumes with remaining count, tick spacing grows by exactly 7.
- Rate change and restart: ch2 rate=9 running; change rate to 2 at cnt=5 -> next tick after 6 more edges, then period 3; restart pulse at cnt=1 -> no tick, next tick 3 edges later.
- One-shot: ch3 oneshot=1, rate=5, restart pulse -> armed=1 for 6 edges, single tick 6 edges after restart, armed=0 after; no further ticks without a new restart; restart during ARMED re-arms from 5.
- Reset mid-operation: assert resetn=0 asynchronously between edges while ch3 is armed and ch0 is mid-count -> tick, armed, cnt all 0 immediately; after release ch0 ticks on the first enabled edge, ch3 stays IDLE.
- Parameter sweep: CHANNELS=1, WIDTH=1, rate=1 -> tick every 2 cycles; channels are independent under random restart/enable checked against a cycle-accurate model.

Source files
------------

// File: rtl/multi_rate_divider_if.sv
// multi_rate_divider_if: per-channel control inputs and tick/armed outputs of the divider bank.
interface multi_rate_divider_if #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 29
);
    logic [CHANNELS-1:0]       enable;
    logic [CHANNELS-1:0]       oneshot;
    logic [CHANNELS-1:0]       restart;
    logic [CHANNELS*WIDTH-1:0] rate;
    logic [CHANNELS-1:0]       tick;
    logic [CHANNELS-1:0]       armed;
    modport master (output enable, oneshot, restart, rate, input tick, armed);
    modport slave  (input enable, oneshot, restart, rate, output tick, armed);
endinterface

// File: rtl/multi_rate_divider.sv
// multi_rate_divider: independent periodic/one-shot down-counter channels emitting one-cycle ticks.
module multi_rate_divider #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 29
) (
    input logic                  CLOCK_50,
    input logic                  resetn,
    multi_rate_divider_if.slave  bus
);
    typedef enum logic {IDLE, ARMED} state_t;
    state_t              st_q  [CHANNELS];
    state_t              st_d  [CHANNELS];
    logic [WIDTH-1:0]    cnt_q [CHANNELS];
    logic [WIDTH-1:0]    cnt_d [CHANNELS];
    logic [CHANNELS-1:0] tick_q, tick_d, armed;
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            tick_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= IDLE;
                cnt_q[i] <= '0;
            end
        end else begin
            tick_q <= tick_d;
            for (int i = 0; i < CHANNELS; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end
    // Priority per channel: restart, then periodic wrap, then one-shot countdown.
    always_comb begin
        tick_d = '0;
        armed  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = cnt_q[i];
            st_d[i]  = st_q[i];
            armed[i] = st_q[i] == ARMED;
            if (bus.restart[i]) begin
                cnt_d[i] = bus.rate[i*WIDTH +: WIDTH];
                st_d[i]  = bus.oneshot[i] ? ARMED : IDLE;
            end else if (!bus.oneshot[i]) begin
                st_d[i] = IDLE;
                if (bus.enable[i]) begin
                    tick_d[i] = cnt_q[i] == '0;
                    cnt_d[i]  = tick_d[i] ? bus.rate[i*WIDTH +: WIDTH] : cnt_q[i] - 1'b1;
                end
            end else if (st_q[i] == ARMED && bus.enable[i]) begin
                tick_d[i] = cnt_q[i] == '0;
                cnt_d[i]  = tick_d[i] ? cnt_q[i] : cnt_q[i] - 1'b1;
                st_d[i]   = tick_d[i] ? IDLE : ARMED;
            end
        end
    end
    assign bus.tick  = tick_q;
    assign bus.armed = armed;
endmodule
